wb_stage: RTL

- Write-back pipeline stage of the RV32I core, directly upstream of the register access interface.
- Registers the memory-stage result and selects the write-back source (ALU, load, CSR, link address).
- Sign- or zero-extends load data and drives rd address, write data and write enable into the register file.
- Also provides write-back-to-read bypass for rs1/rs2 and a 64-bit retired-instruction counter.

---
 rtl/wb_stage.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/wb_stage.sv
// Write-back stage of the RV32I core.
// Registers the memory-stage result, picks the write-back source (ALU, load,
// CSR, link address), extends load data, drives the register-file write port,
// offers a write-back-to-decode bypass and counts retired instructions.
// Optional feature macro: WB_BYPASS_EN. When it is defined, rs1/rs2 are bypassed
// from the write port. When it is undefined, the register-file data passes
// straight through and the hazard unit has to stall on a write-back match.
module wb_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int OPCODE_W   = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  halt,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [OPCODE_W-1:0]   in_opcode,
    input  logic [2:0]            in_funct3,
    input  logic [REG_ADDR_W-1:0] in_rd_addr,
    input  logic [XLEN-1:0]       alu_result,
    input  logic [XLEN-1:0]       mem_rdata,
    input  logic [XLEN-1:0]       csr_rdata,
    input  logic [XLEN-1:0]       pc_plus4,
    output logic                  wb_en,
    output logic [REG_ADDR_W-1:0] wb_rd_addr,
    output logic [XLEN-1:0]       wb_data,
    output logic [OPCODE_W-1:0]   wb_opcode,
    output logic [2:0]            wb_funct3,
    output logic                  load_err,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    input  logic [XLEN-1:0]       rs1_rf_data,
    input  logic [XLEN-1:0]       rs2_rf_data,
    output logic [XLEN-1:0]       rs1_fwd_data,
    output logic [XLEN-1:0]       rs2_fwd_data,
    output logic [63:0]           instret
);

    localparam logic [OPCODE_W-1:0] OP_LOAD   = OPCODE_W'(7'b0000011);
    localparam logic [OPCODE_W-1:0] OP_JAL    = OPCODE_W'(7'b1101111);
    localparam logic [OPCODE_W-1:0] OP_JALR   = OPCODE_W'(7'b1100111);
    localparam logic [OPCODE_W-1:0] OP_SYSTEM = OPCODE_W'(7'b1110011);
    localparam logic [OPCODE_W-1:0] OP_OP     = OPCODE_W'(7'b0110011);
    localparam logic [OPCODE_W-1:0] OP_OPIMM  = OPCODE_W'(7'b0010011);
    localparam logic [OPCODE_W-1:0] OP_LUI    = OPCODE_W'(7'b0110111);
    localparam logic [OPCODE_W-1:0] OP_AUIPC  = OPCODE_W'(7'b0010111);

    typedef enum logic [2:0] {
        SRC_NONE,
        SRC_ALU,
        SRC_LOAD,
        SRC_CSR,
        SRC_LINK
    } src_e;

    // Stage register
    logic                  valid_q, valid_d;
    logic [OPCODE_W-1:0]   opcode_q;
    logic [2:0]            funct3_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic [XLEN-1:0]       alu_q;
    logic [XLEN-1:0]       mem_q;
    logic [XLEN-1:0]       csr_q;
    logic [XLEN-1:0]       pc4_q;
    logic [63:0]           instret_q, instret_d;

    logic                  capture;
    logic                  retire;
    src_e                  src;
    logic [XLEN-1:0]       load_data;
    logic                  load_illegal;
    logic                  bad_load;
    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;

    // A new instruction is taken only when upstream offers one, the stage is
    // not frozen and the slot is not being killed.
    assign capture  = in_valid & ~halt & ~flush;
    // Anything sitting in the stage while not frozen leaves it on this edge,
    // whether or not it writes the register file.
    assign retire   = valid_q & ~halt;
    assign in_ready = ~halt;

    // Next-state for the valid bit and the retired-instruction counter
    always_comb begin
        valid_d   = valid_q;
        instret_d = instret_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (!halt) begin
            valid_d = in_valid;
        end
        if (retire) begin
            instret_d = instret_q + 64'd1;
        end
    end

    // Stage register and counter; payload only loads on capture so a halt holds it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            opcode_q  <= '0;
            funct3_q  <= '0;
            rd_q      <= '0;
            alu_q     <= '0;
            mem_q     <= '0;
            csr_q     <= '0;
            pc4_q     <= '0;
            instret_q <= '0;
        end else begin
            valid_q   <= valid_d;
            instret_q <= instret_d;
            if (capture) begin
                opcode_q <= in_opcode;
                funct3_q <= in_funct3;
                rd_q     <= in_rd_addr;
                alu_q    <= alu_result;
                mem_q    <= mem_rdata;
                csr_q    <= csr_rdata;
                pc4_q    <= pc_plus4;
            end
        end
    end

    // Write-back source from the registered opcode
    always_comb begin
        src = SRC_NONE;
        case (opcode_q)
            OP_LOAD:                         src = SRC_LOAD;
            OP_JAL, OP_JALR:                 src = SRC_LINK;
            OP_SYSTEM:                       src = (funct3_q != 3'b000) ? SRC_CSR : SRC_NONE;
            OP_OP, OP_OPIMM, OP_LUI, OP_AUIPC: src = SRC_ALU;
            default:                         src = SRC_NONE;
        endcase
    end

    // The load word is already aligned; the low address bits pick the lane.
    assign byte_sel = mem_q[{alu_q[1:0], 3'b000} +: 8];
    assign half_sel = mem_q[{alu_q[1], 4'b0000} +: 16];

    // Load lane extraction and extension, flagging the unused funct3 codes
    always_comb begin
        load_data    = '0;
        load_illegal = 1'b0;
        case (funct3_q)
            3'b000:  load_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            3'b100:  load_data = {{(XLEN-8){1'b0}}, byte_sel};
            3'b001:  load_data = {{(XLEN-16){half_sel[15]}}, half_sel};
            3'b101:  load_data = {{(XLEN-16){1'b0}}, half_sel};
            3'b010:  load_data = mem_q;
            default: load_illegal = 1'b1;
        endcase
    end

    assign bad_load = (src == SRC_LOAD) & load_illegal;

    // Halt gates the strobe combinationally so a frozen instruction writes
    // exactly once, in the cycle the freeze is released.
    assign wb_en    = valid_q & (src != SRC_NONE) & (rd_q != '0) & ~halt & ~bad_load;
    assign load_err = valid_q & ~halt & bad_load;

    // Write data mux, forced to zero whenever nothing is written
    always_comb begin
        wb_data = '0;
        if (wb_en) begin
            case (src)
                SRC_ALU:  wb_data = alu_q;
                SRC_LOAD: wb_data = load_data;
                SRC_CSR:  wb_data = csr_q;
                SRC_LINK: wb_data = pc4_q;
                default:  wb_data = '0;
            endcase
        end
    end

    assign wb_rd_addr = rd_q;
    assign wb_opcode  = opcode_q;
    assign wb_funct3  = funct3_q;
    assign instret    = instret_q;

`ifdef WB_BYPASS_EN
    // Both read ports use the same compare-and-select, so they are built from
    // one template; both may hit the same destination in one cycle.
    logic [REG_ADDR_W-1:0] rs_addr [2];
    logic [XLEN-1:0]       rs_rf   [2];
    logic [XLEN-1:0]       rs_fwd  [2];

    assign rs_addr[0]   = rs1_addr;
    assign rs_addr[1]   = rs2_addr;
    assign rs_rf[0]     = rs1_rf_data;
    assign rs_rf[1]     = rs2_rf_data;
    assign rs1_fwd_data = rs_fwd[0];
    assign rs2_fwd_data = rs_fwd[1];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bypass
            assign rs_fwd[gi] = (wb_en && (rs_addr[gi] == rd_q) && (rs_addr[gi] != '0))
                              ? wb_data : rs_rf[gi];
        end
    endgenerate
`else
    // No bypass: the read addresses are not needed here at all.
    logic unused_rs_addr;
    assign unused_rs_addr = ^{rs1_addr, rs2_addr};
    assign rs1_fwd_data   = rs1_rf_data;
    assign rs2_fwd_data   = rs2_rf_data;
`endif

endmodule
